lds_mem_responder: RTL and testbench
====================================

LDS_MEM_RESPONDER -- requirements
Module: lds_mem_responder

Interface
REQ-001 Parameters SHALL be: MEMORY_BUS_WIDTH, default 32, data word width; DEPTH_LOG2, default 8, words per bank = 2^DEPTH_LOG2; LATENCY, default 2, request-to-ack cycles, legal 1..15.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, synchronous, active-low reset.
- mem_rd_en, in, 1, read request strobe.
- mem_wr_en, in, 1, write request strobe.
- mem_addr, in, 32, byte address.
- mem_wr_data, in, MEMORY_BUS_WIDTH, write data.
- mem_tag_req, in, 7, request tag.
- mem_gm_or_lds, in, 1, bank select: 0 = LDS bank, 1 = GM bank.
- mem_ack, out, 1, one-cycle completion pulse.
- mem_tag_resp, out, 7, tag of the completing request.
- mem_rd_data, out, MEMORY_BUS_WIDTH, read data.
- busy, out, 1, queue non-empty.
- err, out, 1, sticky protocol-error flag.

Function
REQ-003 The block SHALL accept a request on any rising edge where mem_rd_en or mem_wr_en is high, capturing {rd, wr, addr, wr_data, tag, bank} into a 2-entry in-order FIFO.
REQ-004 If both strobes are high in one cycle, the request SHALL be treated as a write.
REQ-005 Word index SHALL be mem_addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo bank size.
REQ-006 The FSM SHALL have states IDLE and SERVE. IDLE goes to SERVE when the FIFO is non-empty, loading a down-counter with LATENCY. SERVE decrements the counter each cycle.
REQ-007 When the counter reaches its terminal value, the block SHALL assert mem_ack for exactly one cycle and pop the head. It SHALL then return to IDLE, or reload the counter if the FIFO is still non-empty.
REQ-008 Timing: a request accepted at edge k into an empty, idle block SHALL be acked in cycle k+LATENCY. A queued request SHALL be acked exactly LATENCY cycles after the preceding ack.
REQ-009 Write commit and read sampling SHALL both occur in the ack cycle, so a read issued after a write to the same word returns the new data.
REQ-010 On a write ack, mem_rd_data SHALL be 0. Whenever mem_ack is low, mem_rd_data and mem_tag_resp SHALL be 0.
REQ-011 A request arriving in the same cycle as an ack-pop SHALL be accepted even if the FIFO was full before the pop.
REQ-012 A request arriving while the FIFO is full with no pop SHALL be dropped.
REQ-013 busy SHALL be high whenever the FIFO holds at least one entry.

Reset
REQ-014 With rst low at a rising edge: FIFO empties, FSM goes to IDLE, counter is cleared, and mem_ack, mem_tag_resp, mem_rd_data, busy and err are all 0.
REQ-015 Requests in flight at reset SHALL be discarded without ack. Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-016 With LDS_RESP_ERR_CHECK_EN defined, err SHALL set (sticky until reset) on any of: dropped request (REQ-012), both strobes high together, or mem_addr[1:0] != 0.
REQ-017 With LDS_RESP_ERR_CHECK_EN undefined, err SHALL be tied 0, and no error logic SHALL be synthesized; all other behaviour is unchanged.

Structure
REQ-018 A shared package lds_resp_pkg SHALL hold: the FSM state enum, the FIFO entry struct, tag width 7, and the bank-select encodings.
REQ-019 The 2-entry FIFO SHALL be a sub-module named lds_resp_fifo. Both memory banks SHALL be inline arrays in the top module.

Verification
REQ-020 Write then read, LATENCY=2, checking the read timing:
- Stimulus: write addr 0x10, data 0xDEADBEEF, tag 5, bank 0 at cycle 0; read addr 0x10, tag 6, bank 0 at cycle 3.
- Required response: ack with tag 5 at cycle 2; ack with tag 6 at cycle 5 returning 0xDEADBEEF.
REQ-021 Back-to-back reads:
- Stimulus: reads with tags 1 and 2 in cycles 0 and 1.
- Required response: acks at cycles 2 and 4, in order; busy low from cycle 5.
REQ-022 Bank isolation:
- Stimulus: write 0x1111 to GM bank addr 0x0, then write 0x2222 to LDS bank addr 0x0.
- Required response: reading GM addr 0x0 returns 0x1111, and reading LDS addr 0x0 returns 0x2222.
REQ-023 Wrap and overflow, DEPTH_LOG2=8:
- Stimulus: write 0xAB to addr 0x400, read addr 0x000; then issue 3 requests in consecutive cycles.
- Required response: the read returns 0xAB; the third request is dropped with no ack, and err=1 when LDS_RESP_ERR_CHECK_EN is defined.
REQ-024 Reset mid-operation:
- Stimulus: assert rst low during SERVE, with one entry pending.
- Required response: no ack ever occurs; all outputs are 0 the cycle after reset; a fresh request after reset completes with nominal LATENCY.

Source files
------------

// File: rtl/lds_resp_pkg.sv
// Shared types for the LDS/GM memory responder: FSM states, queued request metadata,
// tag width and bank-select encodings.
package lds_resp_pkg;

  localparam int TAG_W  = 7;
  localparam int ADDR_W = 32;

  localparam logic BANK_LDS = 1'b0;
  localparam logic BANK_GM  = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } lds_state_t;

  // Queued request fields. Write data rides in a parallel lane inside the FIFO
  // because its width is a module parameter.
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic              bank;
  } lds_req_t;

endpackage

// File: rtl/lds_resp_fifo.sv
// Two-entry in-order request FIFO. A push is taken when there is room
// or when the head is popped on the same edge.
module lds_resp_fifo
  import lds_resp_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  lds_req_t          push_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output lds_req_t          head_req,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              push_ok
);

  lds_req_t          req_q  [2];
  logic [DATA_W-1:0] data_q [2];
  logic              rd_ptr;
  logic              wr_ptr;

  assign push_ok   = push && ((count != 2'd2) || pop);
  assign head_req  = req_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop};
    end
  end

  // Storage needs no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      req_q[wr_ptr]  <= push_req;
      data_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/lds_mem_responder.sv
// Fixed-latency responder for an LDS bank and a GM bank, serving queued requests in order.
// Optional feature: define LDS_RESP_ERR_CHECK_EN to enable the sticky protocol-error flag.
module lds_mem_responder
  import lds_resp_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int DEPTH_LOG2       = 8,
  parameter int LATENCY          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_rd_en,
  input  logic                        mem_wr_en,
  input  logic [31:0]                 mem_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data,
  input  logic [6:0]                  mem_tag_req,
  input  logic                        mem_gm_or_lds,
  output logic                        mem_ack,
  output logic [6:0]                  mem_tag_resp,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data,
  output logic                        busy,
  output logic                        err
);

  localparam int         WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  logic [MEMORY_BUS_WIDTH-1:0] lds_mem [WORDS];
  logic [MEMORY_BUS_WIDTH-1:0] gm_mem  [WORDS];

  lds_state_t                  state;
  logic [3:0]                  cnt;
  logic                        push;
  logic                        push_ok;
  logic                        ack;
  lds_req_t                    push_req;
  lds_req_t                    head_req;
  logic [MEMORY_BUS_WIDTH-1:0] head_data;
  logic [1:0]                  count;
  logic [DEPTH_LOG2-1:0]       head_idx;
  logic                        addr_unused;

  assign push = mem_rd_en | mem_wr_en;

  // Both strobes together are a write.
  always_comb begin
    push_req      = '0;
    push_req.rd   = mem_rd_en & ~mem_wr_en;
    push_req.wr   = mem_wr_en;
    push_req.addr = mem_addr;
    push_req.tag  = mem_tag_req;
    push_req.bank = mem_gm_or_lds;
  end

  lds_resp_fifo #(
    .DATA_W (MEMORY_BUS_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_req  (push_req),
    .push_data (mem_wr_data),
    .pop       (ack),
    .head_req  (head_req),
    .head_data (head_data),
    .count     (count),
    .push_ok   (push_ok)
  );

  // Handshake: a request is offered by holding mem_rd_en/mem_wr_en high for one edge;
  // it is taken if the FIFO has room or the head pops on that edge, otherwise dropped.
  // Completion is signalled by a single-cycle mem_ack carrying the request's tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (count != 2'd0) begin
            state <= ST_SERVE;
            cnt   <= LAT;
          end
        end
        ST_SERVE: begin
          if (cnt == 4'd1) begin
            // A request pushed on this same edge is not counted; it waits for IDLE.
            if (count > 2'd1) begin
              cnt <= LAT;
            end else begin
              state <= ST_IDLE;
              cnt   <= 4'd0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign ack         = (state == ST_SERVE) && (cnt == 4'd1);
  assign head_idx    = head_req.addr[DEPTH_LOG2+1:2];
  assign addr_unused = ^{head_req.addr[31:DEPTH_LOG2+2], head_req.addr[1:0]};

  always_ff @(posedge clk) begin
    if (ack && head_req.wr) begin
      if (head_req.bank == BANK_GM) gm_mem[head_idx]  <= head_data;
      else                          lds_mem[head_idx] <= head_data;
    end
  end

  always_comb begin
    mem_rd_data = '0;
    if (ack && head_req.rd) begin
      mem_rd_data = (head_req.bank == BANK_GM) ? gm_mem[head_idx] : lds_mem[head_idx];
    end
  end

  assign mem_ack      = ack;
  assign mem_tag_resp = ack ? head_req.tag : 7'd0;
  assign busy         = (count != 2'd0);

`ifdef LDS_RESP_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((push && !push_ok) || (mem_rd_en && mem_wr_en) ||
                 (push && (mem_addr[1:0] != 2'b00))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic push_ok_unused;

  assign push_ok_unused = push_ok;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_lds_mem_responder.sv
// Bench for lds_mem_responder: directed scenarios plus random traffic, compared against
// a transaction-level model that predicts each request's ack cycle, tag and data.
module tb_lds_mem_responder;

  localparam int W     = 32;
  localparam int DL    = 8;
  localparam int LAT   = 2;
  localparam int WORDS = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_rd_en = 1'b0;
  logic          mem_wr_en = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [W-1:0]  mem_wr_data = '0;
  logic [6:0]    mem_tag_req = '0;
  logic          mem_gm_or_lds = 1'b0;
  logic          mem_ack;
  logic [6:0]    mem_tag_resp;
  logic [W-1:0]  mem_rd_data;
  logic          busy;
  logic          err;

  lds_mem_responder #(
    .MEMORY_BUS_WIDTH (W),
    .DEPTH_LOG2       (DL),
    .LATENCY          (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd_en     (mem_rd_en),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_tag_req   (mem_tag_req),
    .mem_gm_or_lds (mem_gm_or_lds),
    .mem_ack       (mem_ack),
    .mem_tag_resp  (mem_tag_resp),
    .mem_rd_data   (mem_rd_data),
    .busy          (busy),
    .err           (err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int          ack_cyc;
    logic        rd;
    logic        wr;
    int          idx;
    logic        bank;
    logic [6:0]  tag;
    logic [31:0] data;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] ref_lds [WORDS];
  logic [31:0] ref_gm  [WORDS];
  bit          known_lds [WORDS];
  bit          known_gm  [WORDS];
  int          last_ack = -100;
  logic        ref_err  = 1'b0;
  int          cyc      = 0;
  int          ack_seen [128];
  logic [31:0] ack_data [128];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 128; i++) begin
      ack_seen[i] = -1;
      ack_data[i] = '0;
    end
  endtask

  // Driver + model: one clock edge per call, outputs checked #1 after the edge.
  task automatic step(input logic r, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [6:0] t, input logic b);
    pend_t p;
    logic  exp_ack;
    logic  exp_err;
    rst = r; mem_rd_en = rd; mem_wr_en = wr; mem_addr = a;
    mem_wr_data = d; mem_tag_req = t; mem_gm_or_lds = b;
    @(posedge clk);
    if (!r) begin
      pend_q.delete();
      last_ack = -100;
      ref_err  = 1'b0;
    end else if (rd || wr) begin
      if (pend_q.size() < 2) begin
        p.ack_cyc = ((cyc > last_ack) ? cyc : last_ack) + LAT;
        p.wr      = wr;
        p.rd      = !wr;
        p.idx     = int'(a >> 2) % WORDS;
        p.bank    = b;
        p.tag     = t;
        p.data    = d;
        pend_q.push_back(p);
        last_ack  = p.ack_cyc;
      end else begin
        ref_err = 1'b1;
      end
      if (rd && wr) ref_err = 1'b1;
      if (a[1:0] != 2'b00) ref_err = 1'b1;
    end
    #1;
    exp_ack = (pend_q.size() > 0) && (pend_q[0].ack_cyc == cyc);
`ifdef LDS_RESP_ERR_CHECK_EN
    exp_err = ref_err;
`else
    exp_err = 1'b0;
`endif
    check("ack", 32'(mem_ack), 32'(exp_ack));
    check("busy", 32'(busy), 32'(pend_q.size() != 0));
    check("err", 32'(err), 32'(exp_err));
    if (mem_ack) begin
      ack_seen[mem_tag_resp] = cyc;
      ack_data[mem_tag_resp] = mem_rd_data;
    end
    if (exp_ack) begin
      p = pend_q.pop_front();
      check("tag", 32'(mem_tag_resp), 32'(p.tag));
      if (p.wr) begin
        check("wr_rdata", mem_rd_data, 32'd0);
        if (p.bank) begin ref_gm[p.idx] = p.data; known_gm[p.idx] = 1'b1; end
        else        begin ref_lds[p.idx] = p.data; known_lds[p.idx] = 1'b1; end
      end else if (p.bank && known_gm[p.idx]) begin
        check("rdata_gm", mem_rd_data, ref_gm[p.idx]);
      end else if (!p.bank && known_lds[p.idx]) begin
        check("rdata_lds", mem_rd_data, ref_lds[p.idx]);
      end
    end else begin
      check("idle_tag", 32'(mem_tag_resp), 32'd0);
      check("idle_rdata", mem_rd_data, 32'd0);
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 7'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (pend_q.size() != 0 || busy); i++) idle();
    idle();
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  int t0;

  initial begin
    clear_seen();
    // Reset
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 7'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 7'd3, 1'b0);
    check("rst_ack", 32'(mem_ack), 32'd0);
    idle();

    // Write then read the same word
    clear_seen();
    t0 = cyc;
    step(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 7'd5, 1'b0);
    idle(); idle();
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 7'd6, 1'b0);
    drain();
    check("wr_ack_cyc", 32'(ack_seen[5] - t0), 32'd2);
    check("rd_ack_cyc", 32'(ack_seen[6] - t0), 32'd5);
    check("rd_data", ack_data[6], 32'hDEADBEEF);

    // Back-to-back reads
    clear_seen();
    t0 = cyc;
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 7'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 7'd2, 1'b0);
    idle(); idle(); idle();
    check("busy_last_ack", 32'(busy), 32'd1);
    idle();
    check("busy_low", 32'(busy), 32'd0);
    check("b2b_ack1", 32'(ack_seen[1] - t0), 32'd2);
    check("b2b_ack2", 32'(ack_seen[2] - t0), 32'd4);

    // Bank isolation
    clear_seen();
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h1111, 7'd10, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h2222, 7'd11, 1'b0);
    drain();
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 7'd12, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 7'd13, 1'b0);
    drain();
    check("gm_data", ack_data[12], 32'h1111);
    check("lds_data", ack_data[13], 32'h2222);

    // Address wrap, then overflow with three consecutive requests
    clear_seen();
    step(1'b1, 1'b0, 1'b1, 32'h400, 32'hAB, 7'd20, 1'b0);
    drain();
    step(1'b1, 1'b1, 1'b0, 32'h000, 32'd0, 7'd21, 1'b0);
    drain();
    check("wrap_data", ack_data[21], 32'hAB);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 7'd22, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 7'd23, 1'b0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 7'd24, 1'b0);
    drain();
    check("ovf_ack22", 32'(ack_seen[22] >= 0), 32'd1);
    check("ovf_ack23", 32'(ack_seen[23] >= 0), 32'd1);
    check("ovf_drop24", 32'(ack_seen[24]), 32'hFFFF_FFFF);
`ifdef LDS_RESP_ERR_CHECK_EN
    check("ovf_err", 32'(err), 32'd1);
`else
    check("ovf_err", 32'(err), 32'd0);
`endif

    // Reset while serving one entry
    clear_seen();
    t0 = cyc;
    step(1'b1, 1'b0, 1'b1, 32'h20, 32'h5555, 7'd30, 1'b0);
    idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 7'd0, 1'b0);
    check("rst_mid_ack", 32'(mem_ack), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    t0 = cyc;
    step(1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 7'd31, 1'b0);
    drain();
    check("rst_no_ack30", 32'(ack_seen[30]), 32'hFFFF_FFFF);
    check("rst_fresh_lat", 32'(ack_seen[31] - t0), 32'(LAT));
    check("rst_mem_kept", ack_data[31], 32'hAB);

    // Preload the words used by random traffic
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom(), 7'(i), 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom(), 7'(i + 8), 1'b1);
      drain();
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic        rd;
      logic        wr;
      logic [31:0] a;
      int          kind;
      if ($urandom_range(99) < 45) begin
        kind = $urandom_range(99);
        rd   = (kind < 50);
        wr   = (kind >= 45);
        a    = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(7)) << 2);
        if ($urandom_range(99) < 3) a[1:0] = 2'($urandom_range(3, 1));
        step(1'b1, rd, wr, a, $urandom(), 7'($urandom_range(127)), 1'($urandom_range(1)));
      end else begin
        idle();
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
